// File: rtl/fifo4_reader_if.sv
// Handshake bundle between fifo4_reader, its upstream FIFO and the downstream consumer.
interface fifo4_reader_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             fifo_empty;
    logic [3:0]       fifo_dout;
    logic             fifo_read;
    logic [3:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             busy;

    modport slave (
        input  enable, fifo_empty, fifo_dout, out_ready,
        output fifo_read, out_data, out_valid, count, busy
    );

    modport master (
        output enable, fifo_empty, fifo_dout, out_ready,
        input  fifo_read, out_data, out_valid, count, busy
    );
endinterface

// File: rtl/fifo4_reader.sv
// Pops 4-bit words from a one-cycle-latency FIFO into a two-entry skid buffer
// and presents them downstream with a valid/ready handshake.
module fifo4_reader #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           clr,
    fifo4_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       occ_q, occ_d;
    logic [3:0]       head_q, head_d;
    logic [3:0]       skid_q, skid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_read_q, fifo_read_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             capture_s;
    logic             transfer_s;
    logic             issue_s;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer update: the captured word always lands behind whatever survives this cycle's transfer
    always_comb begin
        capture_s  = (state_q == ST_WAIT);
        transfer_s = out_valid_q & bus.out_ready;
        head_d     = head_q;
        skid_d     = skid_q;
        occ_d      = occ_q;
        case ({capture_s, transfer_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = bus.fifo_dout;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    skid_d = bus.fifo_dout;
                    occ_d  = 2'd2;
                end else begin
                    occ_d  = occ_q;
                end
            end
            2'b01: begin
                head_d = skid_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = bus.fifo_dout;
                end else begin
                    head_d = skid_q;
                    skid_d = bus.fifo_dout;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        count_d = count_q + {{(CNT_W-1){1'b0}}, transfer_s};
        issue_s = bus.enable & ~bus.fifo_empty & (occ_d < 2'd2);
    end

    // Next-state logic; fifo_empty and enable only matter when leaving IDLE or WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (issue_s) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode, computed one cycle early so every output comes from a flop
    always_comb begin
        fifo_read_d = (state_d == ST_POP);
        out_valid_d = (occ_d != 2'd0);
        busy_d      = (state_d != ST_IDLE) | (occ_d != 2'd0);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            occ_q       <= 2'd0;
            head_q      <= 4'h0;
            skid_q      <= 4'h0;
            count_q     <= {CNT_W{1'b0}};
            fifo_read_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            count_q     <= count_d;
            fifo_read_q <= fifo_read_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.fifo_read = fifo_read_q;
    assign bus.out_data  = head_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;

endmodule
